// File: rtl/contra_pkg.sv
// rtl/contra_pkg.sv - shared FSM encoding, width helpers and saturating subtract for contra_stretch
package contra_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_LOAD = 2'd2;

  function automatic int gain_width(input int w, input int frac);
    return w + frac;
  endfunction

  function automatic int prod_width(input int w, input int frac);
    return 2 * w + frac;
  endfunction

  function automatic int clamp_max(input int w);
    return (1 << w) - 1;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? a - b : 32'd0;
  endfunction

endpackage

// File: rtl/contra_stretch_seq_divider.sv
// rtl/contra_stretch_seq_divider.sv - restoring divider, one quotient bit per cycle
// The dividend register doubles as the quotient register: bits shift out the top, quotient bits in the bottom.
module seq_divider #(
  parameter int N = 16,
  parameter int D = 8
) (
  input  logic         clk_i,
  input  logic         start_i,
  input  logic         abort_i,
  input  logic [N-1:0] dividend_i,
  input  logic [D-1:0] divisor_i,
  output logic [N-1:0] quot_o,
  output logic         done_o
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N-1:0]  dq_q;
  logic [D-1:0]  dvs_q;
  logic [D-1:0]  rem_q;
  logic [D-1:0]  rem_d;
  logic [D:0]    trial;
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic          take;

  always_comb begin
    trial = {rem_q, dq_q[N-1]};
    take  = (trial >= {1'b0, dvs_q});
    rem_d = take ? D'(trial - {1'b0, dvs_q}) : D'(trial);
  end

  // A fixed cycle count means a zero divisor just yields all-ones, never a hang.
  always_ff @(posedge clk_i) begin
    if (abort_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      dq_q  <= dividend_i;
      dvs_q <= divisor_i;
      rem_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      dq_q  <= {dq_q[N-2:0], take};
      rem_q <= rem_d;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == LAST) run_q <= 1'b0;
    end
  end

  assign quot_o = dq_q;
  assign done_o = run_q && (cnt_q == LAST);

endmodule

// File: rtl/contra_stretch.sv
// rtl/contra_stretch.sv - per-frame min/max contrast stretcher with sequential gain divider
module contra_stretch
  import contra_pkg::*;
#(
  parameter int W         = 8,
  parameter int CH        = 1,
  parameter int FRAC      = 8,
  parameter int MIN_RANGE = 4,
  parameter int POLARITY  = 1
) (
  input  logic            iclk,
  input  logic            irst,
  input  logic            ien,
  input  logic [CH*W-1:0] idata,
  input  logic            ivs,
  input  logic            ihs,
  input  logic            ide,
  output logic [CH*W-1:0] odata,
  output logic            ovs,
  output logic            ohs,
  output logic            ode,
  output logic            obusy,
  output logic            oparam_valid
);

  localparam int GW    = gain_width(W, FRAC);
  localparam int PW    = prod_width(W, FRAC);
  localparam int PW1   = PW + 1;
  localparam int W1    = W + 1;
  localparam int CLAMP = clamp_max(W);
  localparam logic            POL      = (POLARITY != 0);
  localparam logic [GW-1:0]   DIVIDEND = {{W{1'b1}}, {FRAC{1'b0}}};
  localparam logic [PW:0]     ROUND    = PW1'(1) << (FRAC - 1);
  localparam logic [PW:0]     SAT      = PW1'(CLAMP);
  localparam logic [W-1:0]    SAT_W    = {W{1'b1}};
  localparam logic [W:0]      MIN_R    = W1'(MIN_RANGE);

  logic [1:0]    state_q, state_d;
  logic          prev_vs_q;
  logic          valid_q;
  logic          strobe;
  logic          load;
  logic [2:0]    vs_sr_q, hs_sr_q, de_sr_q;
  logic [CH-1:0] div_done;

  assign strobe       = (ivs == POL) && (prev_vs_q != POL);
  assign load         = (state_q == ST_LOAD) && !strobe;
  assign obusy        = (state_q != ST_IDLE);
  assign oparam_valid = valid_q;
  assign ovs          = vs_sr_q[2];
  assign ohs          = hs_sr_q[2];
  assign ode          = de_sr_q[2];

  // A strobe in any state restarts the divide from a fresh snapshot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (strobe) state_d = ST_DIV;
      ST_DIV:  if (strobe) state_d = ST_DIV; else if (&div_done) state_d = ST_LOAD;
      ST_LOAD: state_d = strobe ? ST_DIV : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q   <= ST_IDLE;
      prev_vs_q <= !POL;
      valid_q   <= 1'b0;
      vs_sr_q   <= '0;
      hs_sr_q   <= '0;
      de_sr_q   <= '0;
    end else begin
      state_q   <= state_d;
      prev_vs_q <= ivs;
      if (load) valid_q <= 1'b1;
      vs_sr_q   <= {vs_sr_q[1:0], ivs};
      hs_sr_q   <= {hs_sr_q[1:0], ihs};
      de_sr_q   <= {de_sr_q[1:0], ide};
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [W-1:0]  pix;
    logic [W-1:0]  min_q, max_q, range_d, smin_q, amin_q;
    logic          sbyp_q, abyp_q;
    logic [GW-1:0] quot, again_q, g1_q;
    logic [W-1:0]  p1_q, n1_q, p2_q, out_q, stretched;
    logic          byp1_q, byp2_q;
    logic [PW-1:0] m_q;
    logic [PW:0]   rnd, shf;

    assign pix     = idata[c*W +: W];
    assign range_d = (max_q < min_q) ? '0 : max_q - min_q;

    always_ff @(posedge iclk) begin
      if (irst || strobe) begin
        min_q <= '1;
        max_q <= '0;
      end else if (ide) begin
        if (pix < min_q) min_q <= pix;
        if (pix > max_q) max_q <= pix;
      end
    end

    always_ff @(posedge iclk) begin
      if (irst) begin
        smin_q  <= '0;
        sbyp_q  <= 1'b1;
        amin_q  <= '0;
        again_q <= '0;
        abyp_q  <= 1'b1;
      end else begin
        if (strobe) begin
          smin_q <= min_q;
          sbyp_q <= ({1'b0, range_d} < MIN_R);
        end
        if (load) begin
          amin_q  <= smin_q;
          again_q <= quot;
          abyp_q  <= sbyp_q;
        end
      end
    end

    seq_divider #(.N(GW), .D(W)) u_div (
      .clk_i      (iclk),
      .start_i    (strobe),
      .abort_i    (irst),
      .dividend_i (DIVIDEND),
      .divisor_i  (range_d),
      .quot_o     (quot),
      .done_o     (div_done[c])
    );

    always_comb begin
      rnd       = {1'b0, m_q} + ROUND;
      shf       = rnd >> FRAC;
      stretched = (shf > SAT) ? SAT_W : shf[W-1:0];
    end

    // Gain and bypass are latched at S1 so in-flight pixels ignore a later load.
    always_ff @(posedge iclk) begin
      if (irst) begin
        p1_q   <= '0;
        n1_q   <= '0;
        g1_q   <= '0;
        byp1_q <= 1'b0;
        p2_q   <= '0;
        m_q    <= '0;
        byp2_q <= 1'b0;
        out_q  <= '0;
      end else begin
        p1_q   <= pix;
        n1_q   <= W'(sat_sub(32'(pix), 32'(amin_q)));
        g1_q   <= again_q;
        byp1_q <= !ien || abyp_q || !valid_q;
        p2_q   <= p1_q;
        m_q    <= PW'(n1_q) * PW'(g1_q);
        byp2_q <= byp1_q;
        out_q  <= byp2_q ? p2_q : stretched;
      end
    end

    assign odata[c*W +: W] = out_q;
  end

endmodule

// File: tb/tb_contra_stretch.sv
// tb/tb_contra_stretch.sv - randomized bench for contra_stretch against a frame-level reference model
module tb_contra_stretch;

  localparam int W       = 8;
  localparam int CH      = 3;
  localparam int FRAC    = 8;
  localparam int MINR    = 4;
  localparam int LOADLAT = W + FRAC + 1;

  logic            iclk = 1'b0;
  logic            irst, ien, ivs, ihs, ide;
  logic [CH*W-1:0] idata, odata;
  logic            ovs, ohs, ode, obusy, oparam_valid;

  contra_stretch #(.W(W), .CH(CH), .FRAC(FRAC), .MIN_RANGE(MINR), .POLARITY(1)) dut (
    .iclk(iclk), .irst(irst), .ien(ien), .idata(idata),
    .ivs(ivs), .ihs(ihs), .ide(ide),
    .odata(odata), .ovs(ovs), .ohs(ohs), .ode(ode),
    .obusy(obusy), .oparam_valid(oparam_valid)
  );

  always #5 iclk = ~iclk;

  typedef struct packed {
    logic [CH*W-1:0] d;
    logic            vs;
    logic            hs;
    logic            de;
  } out_t;

  int checks = 0;
  int failures = 0;

  int acc_min[CH], acc_max[CH], pend_min[CH], pend_gain[CH], act_min[CH], act_gain[CH];
  bit pend_byp[CH], act_byp[CH];
  bit m_valid, m_prev_vs;
  int cd;
  out_t pipe[3];
  logic [CH*W-1:0] hist[$];
  int r_base[CH], r_spread[CH];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_px(input int p, input int c, input bit en);
    int n, v;
    if (!en || act_byp[c] || !m_valid) return p;
    n = (p > act_min[c]) ? p - act_min[c] : 0;
    v = (n * act_gain[c] + (1 << (FRAC - 1))) >> FRAC;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      acc_min[c] = 255; acc_max[c] = 0;
      pend_min[c] = 0; pend_gain[c] = 0; pend_byp[c] = 1'b1;
      act_min[c] = 0; act_gain[c] = 0; act_byp[c] = 1'b1;
    end
    m_valid = 1'b0; m_prev_vs = 1'b0; cd = 0;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
  endtask

  task automatic step();
    out_t e, x;
    bit strobe;
    int p, rng;
    if (irst) begin
      model_reset();
    end else begin
      e.vs = ivs; e.hs = ihs; e.de = ide; e.d = '0;
      for (int c = 0; c < CH; c++) begin
        p = int'(idata[c*W +: W]);
        e.d[c*W +: W] = W'(model_px(p, c, ien));
      end
      pipe[2] = pipe[1]; pipe[1] = pipe[0]; pipe[0] = e;
      strobe = ivs && !m_prev_vs;
      m_prev_vs = ivs;
      if (strobe) begin
        for (int c = 0; c < CH; c++) begin
          rng = (acc_max[c] < acc_min[c]) ? 0 : acc_max[c] - acc_min[c];
          pend_min[c]  = acc_min[c];
          pend_byp[c]  = (rng < MINR);
          pend_gain[c] = (rng == 0) ? 0 : (255 << FRAC) / rng;
          acc_min[c] = 255; acc_max[c] = 0;
        end
        cd = LOADLAT;
      end else begin
        if (ide) begin
          for (int c = 0; c < CH; c++) begin
            p = int'(idata[c*W +: W]);
            if (p < acc_min[c]) acc_min[c] = p;
            if (p > acc_max[c]) acc_max[c] = p;
          end
        end
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin
            for (int c = 0; c < CH; c++) begin
              act_min[c] = pend_min[c]; act_gain[c] = pend_gain[c]; act_byp[c] = pend_byp[c];
            end
            m_valid = 1'b1;
          end
        end
      end
    end
    @(posedge iclk);
    @(negedge iclk);
    x = pipe[2];
    checks++;
    if ({odata, ovs, ohs, ode, obusy, oparam_valid} !== {x.d, x.vs, x.hs, x.de, (cd > 0), m_valid}) begin
      failures++;
      $display("FAIL cycle%0d outputs: got d=%h vs=%b hs=%b de=%b busy=%b pv=%b want d=%h vs=%b hs=%b de=%b busy=%b pv=%b",
               hist.size(), odata, ovs, ohs, ode, obusy, oparam_valid,
               x.d, x.vs, x.hs, x.de, (cd > 0), m_valid);
    end
    hist.push_back(odata);
  endtask

  task automatic drive(input bit vs, input bit hs, input bit de, input bit en,
                       input int d0, input int d1, input int d2);
    ivs = vs; ihs = hs; ide = de; ien = en;
    idata = {W'(d2), W'(d1), W'(d0)};
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
  endtask

  function automatic int px(input int idx, input int c);
    logic [CH*W-1:0] v;
    v = hist[idx + 2];
    return int'(v[c*W +: W]);
  endfunction

  function automatic int rpx(input int c);
    return r_base[c] + $urandom_range(0, r_spread[c]);
  endfunction

  // Steps from a strobe until obusy drops; bounded so a stuck FSM still ends the run.
  task automatic busy_len(input string name, input int exp);
    int n;
    n = 0;
    while (obusy && n < 40) begin
      drive(n < 1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
      n++;
    end
    chk(name, n, exp);
  endtask

  initial begin
    int i;
    int s_in[5], s_out[5], c1[5], c2[5];
    int spreads[6];
    s_in  = '{50, 100, 150, 40, 200};
    s_out = '{0, 127, 255, 0, 255};
    c1    = '{0, 200, 255, 17, 128};
    c2    = '{90, 100, 5, 255, 101};
    spreads = '{0, 1, 3, 4, 60, 255};

    irst = 1'b1; ien = 1'b1; ivs = 1'b0; ihs = 1'b0; ide = 1'b0; idata = '0;
    repeat (3) step();
    chk("reset_odata", int'(odata), 0);
    chk("reset_ode", int'(ode), 0);
    chk("reset_busy", int'(obusy), 0);
    chk("reset_pv", int'(oparam_valid), 0);
    irst = 1'b0;

    i = hist.size();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 10, 20, 30);
    idle(2);
    chk("preload_pass", px(i, 0), 10);

    // Frame A: ch0 50..150, ch1 0..255, ch2 100..102
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    for (int k = 0; k < 24; k++)
      drive(1'b0, (k % 8) == 0, 1'b1, 1'b1,
            k == 0 ? 50 : k == 1 ? 150 : $urandom_range(51, 149),
            k == 0 ? 0  : k == 1 ? 255 : $urandom_range(0, 255),
            k == 0 ? 100 : k == 1 ? 102 : 101);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    busy_len("load_busy_len", LOADLAT);
    chk("pv_after_load", int'(oparam_valid), 1);
    chk("model_gain_ch0", act_gain[0], 652);
    chk("model_gain_ch1", act_gain[1], 256);
    chk("model_byp_ch2", int'(act_byp[2]), 1);

    i = hist.size();
    for (int k = 0; k < 5; k++) drive(1'b0, k == 0, 1'b1, 1'b1, s_in[k], c1[k], c2[k]);
    idle(2);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stretch_ch0_%0d", k), px(i + k, 0), s_out[k]);
      chk($sformatf("ident_ch1_%0d", k), px(i + k, 1), c1[k]);
      chk($sformatf("byp_ch2_%0d", k), px(i + k, 2), c2[k]);
    end

    i = hist.size();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 100, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 100, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 150, 0, 0);
    idle(2);
    chk("ien1_a", px(i, 0), 127);
    chk("ien0", px(i + 1, 0), 100);
    chk("ien1_b", px(i + 2, 0), 255);

    // Flat frame: ch0 all 77 gives range 0 and bypass
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    busy_len("busy_frame_c", LOADLAT);
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b0, 1'b1, 1'b1, 77, $urandom_range(0, 255), 101);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    busy_len("flat_busy_len", LOADLAT);
    chk("flat_model_byp", int'(act_byp[0]), 1);
    i = hist.size();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 90, 0, 0);
    idle(2);
    chk("flat_pass", px(i, 0), 90);

    // Restart: frame D spans 0..255, second snapshot 60..160
    drive(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 255, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 60, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 160, 0, 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 110, 0, 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    busy_len("restart_busy_len", LOADLAT);
    i = hist.size();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 110, 0, 0);
    idle(2);
    chk("restart_params", px(i, 0), 127);

    // Reset mid-DIV and mid-frame
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0);
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 1'b1, 1'b1, $urandom_range(0, 255), 5, 6);
    irst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 200, 200, 200);
    irst = 1'b0;
    chk("rst_odata", int'(odata), 0);
    chk("rst_syncs", int'({ovs, ohs, ode}), 0);
    chk("rst_busy", int'(obusy), 0);
    chk("rst_pv", int'(oparam_valid), 0);
    i = hist.size();
    drive(1'b0, 1'b0, 1'b1, 1'b1, 33, 44, 55);
    idle(20);
    chk("post_rst_pass", px(i, 0), 33);
    chk("post_rst_no_load", int'(oparam_valid), 0);

    // Randomized frames, short blanking forces restarts
    for (int f = 0; f < 60; f++) begin
      int vsl, lines, ppl, blank;
      vsl = $urandom_range(1, 3); lines = $urandom_range(1, 6);
      ppl = $urandom_range(1, 24); blank = $urandom_range(0, 25);
      for (int c = 0; c < CH; c++) begin
        r_spread[c] = spreads[$urandom_range(0, 5)];
        r_base[c]   = $urandom_range(0, 255 - r_spread[c]);
      end
      for (int k = 0; k < vsl; k++) drive(1'b1, 1'b0, 1'b0, $urandom_range(0, 1), rpx(0), rpx(1), rpx(2));
      for (int l = 0; l < lines; l++) begin
        drive(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0);
        for (int p = 0; p < ppl; p++)
          drive(1'b0, 1'b0, $urandom_range(0, 7) != 0, $urandom_range(0, 9) != 0, rpx(0), rpx(1), rpx(2));
      end
      for (int b = 0; b < blank; b++) drive(1'b0, 1'b0, 1'b0, 1'b1, rpx(0), rpx(1), rpx(2));
      if ($urandom_range(0, 29) == 0) begin
        irst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
        irst = 1'b0;
      end
    end
    idle(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
